// File: rtl/cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined add/subtract unit. Each of STAGES slices resolves WIDTH/STAGES
//   result bits with 4-bit carry-lookahead groups. The carry between slices
//   is registered. Not-yet-used operand bits travel forward with the
//   operation, and finished low sum bits are carried along until the whole
//   word emerges aligned from the last stage. Optional signed saturation
//   and zero/neg flags are applied in the last stage. A global valid/ready
//   stall freezes the whole pipe.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake (in_ready = !(out_valid && !out_ready))
//   a, b               operands, WIDTH bits
//   op                 00 ADD, 01 SUB, 10 ADC, 11 SBB
//   cin                carry-in for ADC/SBB (SBB: 1 = no borrow)
//   sat                clamp to signed max/min on overflow
//   out_valid/out_ready output handshake
//   sum, cout, ovf, zero, neg  result and flags (cout/ovf are raw values)
// ---------------------------------------------------------------------------
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SLICE  = WIDTH / STAGES;
    localparam int GROUPS = SLICE / 4;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8 || WIDTH > 64 ||
            STAGES < 1 || STAGES > 4 || (WIDTH % (4 * STAGES)) != 0) begin : g_bad_params
            $fatal(1, "cla_addsub_pipe: illegal WIDTH/STAGES combination");
        end
    endgenerate

    // One in-flight operation. Bits of sum above the slices already
    // resolved are don't-care; carry is the carry into the next slice.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;     // b, already inverted for SUB/SBB
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             c_msb;  // carry into the MSB (last stage only)
        logic             sat;
        logic             ovf;
        logic             zero;
        logic             neg;
    } stage_t;

    // 4-bit lookahead group: returns {carry out, carry into bit 3, sum}.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] p, g, c;
        logic       gg, pp;
        p    = x ^ y;
        g    = x & y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp   = &p;
        return {gg | (pp & c0), c[3], p ^ c};
    endfunction

    stage_t pipe_q   [STAGES];
    stage_t stage_d  [STAGES];
    stage_t stage_in [STAGES];
    stage_t entry;
    logic   advance;

    assign out_valid = pipe_q[STAGES-1].valid;
    assign in_ready  = !(out_valid && !out_ready);
    assign advance   = in_ready;

    always_comb begin
        entry       = '0;
        entry.valid = in_valid;
        entry.a     = a;
        entry.bx    = op[0] ? ~b : b;
        // ADD: 0, SUB: 1, ADC/SBB: cin
        entry.carry = op[1] ? cin : op[0];
        entry.sat   = sat;
    end

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_src
            if (s == 0) begin : g_first
                assign stage_in[s] = entry;
            end else begin : g_next
                assign stage_in[s] = pipe_q[s-1];
            end
        end
    endgenerate

    always_comb begin
        stage_t     cur;
        logic       carry;
        logic [5:0] r;
        int         idx;
        for (int s = 0; s < STAGES; s++) begin
            // NOTE: every variable gets a value on every path before use, so
            // this block stays purely combinational and infers no latches.
            cur   = stage_in[s];
            carry = cur.carry;
            r     = '0;
            for (int g = 0; g < GROUPS; g++) begin
                idx              = s * SLICE + g * 4;
                r                = cla4(cur.a[idx +: 4], cur.bx[idx +: 4], carry);
                cur.sum[idx +: 4] = r[3:0];
                carry            = r[5];
            end
            cur.c_msb = r[4];
            cur.carry = carry;
            if (s == STAGES - 1) begin
                cur.ovf = cur.c_msb ^ carry;
                if (cur.sat && cur.ovf) begin
                    cur.sum = cur.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                end
                cur.zero = (cur.sum == '0);
                cur.neg  = cur.sum[WIDTH-1];
            end
            stage_d[s] = cur;
        end
    end

    // NOTE: the datapath registers are reset as well as the valid bits,
    // because the output flags come straight from the last stage and must
    // read zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                pipe_q[s] <= '0;
            end
        end else if (advance) begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value on the same edge.
            for (int s = 0; s < STAGES; s++) begin
                if (stage_d[s].valid) begin
                    pipe_q[s] <= stage_d[s];
                end else begin
                    pipe_q[s].valid <= 1'b0;
                end
            end
        end
    end

    assign sum  = pipe_q[STAGES-1].sum;
    assign cout = pipe_q[STAGES-1].carry;
    assign ovf  = pipe_q[STAGES-1].ovf;
    assign zero = pipe_q[STAGES-1].zero;
    assign neg  = pipe_q[STAGES-1].neg;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_addsub_pipe
//   Self-checking bench for cla_addsub_pipe at WIDTH=16, STAGES=2.
//   Expected results come from integer arithmetic; timing comes from a
//   slot model of a STAGES-deep pipe with a global stall.
// ---------------------------------------------------------------------------
module tb_cla_addsub_pipe;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic         cin, sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf, zero, neg;

    cla_addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] sum;
        logic         cout, ovf, zero, neg;
    } exp_t;

    exp_t mslot [S];
    int   errors    = 0;
    int   checks    = 0;
    int   delivered = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic [1:0] opv, input logic cv, input logic sv);
        exp_t         e;
        logic [W-1:0] bx;
        int           c, sa, sb, sres;
        int unsigned  u;
        bx   = opv[0] ? ~bv : bv;
        c    = (opv == 2'b00) ? 0 : (opv == 2'b01) ? 1 : int'(cv);
        u    = av;
        u    = u + bx + c;
        sa   = $signed(av);
        sb   = $signed(bx);
        sres = sa + sb + c;
        e.v    = 1'b1;
        e.cout = (u >= (1 << W));
        e.ovf  = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
        e.sum  = u[W-1:0];
        if (sv && e.ovf) e.sum = av[W-1] ? 16'h8000 : 16'h7FFF;
        e.zero = (e.sum == 0);
        e.neg  = e.sum[W-1];
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < S; i++) mslot[i] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    // One clock cycle, entered just after a falling edge.
    task automatic cycle(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [1:0] opv, input logic cv, input logic sv,
                         input logic ordy, output logic accepted);
        logic stall;
        in_valid  = iv;
        a         = av;
        b         = bv;
        op        = opv;
        cin       = cv;
        sat       = sv;
        out_ready = ordy;
        #1;
        stall = mslot[S-1].v && !ordy;
        check("out_valid", out_valid, mslot[S-1].v);
        check("in_ready", in_ready, !stall);
        if (mslot[S-1].v) begin
            check("sum",  sum,  mslot[S-1].sum);
            check("cout", cout, mslot[S-1].cout);
            check("ovf",  ovf,  mslot[S-1].ovf);
            check("zero", zero, mslot[S-1].zero);
            check("neg",  neg,  mslot[S-1].neg);
        end
        accepted = iv && !stall;
        if (!stall) begin
            if (mslot[S-1].v) delivered++;
            for (int i = S - 1; i > 0; i--) mslot[i] = mslot[i-1];
            if (iv) mslot[0] = ref_op(av, bv, opv, cv, sv);
            else    mslot[0].v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic op1(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [1:0] opv, input logic cv, input logic sv);
        logic acc;
        cycle(1'b1, av, bv, opv, cv, sv, 1'b1, acc);
        check("accept", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 16'($urandom), 2'($urandom), 1'b1, 1'b1, 1'b1, acc);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_flags", {cout, ovf, zero, neg}, 4'b0000);
    endtask

    initial begin
        logic acc;
        int   stall_left, issued, start_deliv;
        logic [W-1:0] ra, rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        cin       = 1'b0;
        sat       = 1'b0;
        out_ready = 1'b1;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Directed corner cases
        op1(16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0);
        op1(16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b1);
        op1(16'h8000, 16'h0001, 2'b01, 1'b0, 1'b1);
        op1(16'h0000, 16'h0001, 2'b01, 1'b0, 1'b0);
        op1(16'h0005, 16'h0005, 2'b01, 1'b0, 1'b0);
        op1(16'hFFFF, 16'h0001, 2'b00, 1'b0, 1'b0);
        op1(16'h0000, 16'h0000, 2'b10, 1'b1, 1'b0);
        op1(16'h0000, 16'h0001, 2'b11, 1'b0, 1'b0);
        op1(16'h8000, 16'h7FFF, 2'b11, 1'b1, 1'b1);
        idle(3);

        // Hard-coded spot checks on the first directed result, two cycles after acceptance
        op1(16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0);
        check("lat1_out_valid", out_valid, 1'b0);
        cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, acc);
        check("d_sum", sum, 16'h8000);
        check("d_flags", {out_valid, ovf, cout, neg, zero}, 5'b11010);
        idle(2);

        // Backpressure: 5 back-to-back ops, out_ready low for 4 cycles
        // starting when the first result appears.
        issued      = 0;
        stall_left  = 4;
        start_deliv = delivered;
        for (int cyc = 0; cyc < 40; cyc++) begin
            logic ordy;
            ordy = 1'b1;
            if (mslot[S-1].v && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            cycle(issued < 5, 16'h1000 + 16'(issued), 16'h0011 * 16'(issued), 2'b00, 1'b0, 1'b0, ordy, acc);
            if (acc) issued++;
        end
        check("bp_issued", issued, 5);
        check("bp_delivered", delivered - start_deliv, 5);

        // Reset with two operations in flight
        op1(16'h1234, 16'h1111, 2'b00, 1'b0, 1'b0);
        op1(16'h4321, 16'h0001, 2'b01, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        clear_model();
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        op1(16'h00F0, 16'h000F, 2'b00, 1'b0, 1'b0);
        check("post_rst_lat1", out_valid, 1'b0);
        cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, acc);
        check("post_rst_sum", {out_valid, sum}, {1'b1, 16'h00FF});
        idle(3);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 16'h7FFF;
                1:       ra = 16'h8000;
                2:       ra = 16'hFFFF;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 16'h0000;
                1:       rb = 16'h0001;
                2:       rb = 16'h8000;
                default: rb = 16'($urandom);
            endcase
            cycle($urandom_range(0, 3) != 0, ra, rb, 2'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, acc);
        end
        idle(4);
        check("drained", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
